// File: rtl/bat_amateur_pkg.sv
// Shared types and constants for the BatAmateur boot sequencer.
package bat_amateur_pkg;

   localparam int DEFAULT_ADDRESS_WIDTH = 16;
   localparam int DEFAULT_DATA_WIDTH    = 16;
   localparam int WAIT_W                = 16;

   localparam logic RAM_WRITE = 1'b0;
   localparam logic RAM_READ  = 1'b1;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      RELEASE = 2'd1,
      RUN     = 2'd2,
      STOP    = 2'd3
   } arb_state_e;

endpackage

// File: rtl/bat_amateur_wait_counter.sv
// Loadable down-counter with a zero flag, used to time the turnaround and the CPU stop window.
// Latency: the loaded value is visible the cycle after load; the counter decrements once per cycle until it reaches zero.
// Backpressure: none; load takes priority over the decrement.
module bat_amateur_wait_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             zero
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/bat_amateur_boot_arbiter.sv
// Boot sequencer and RAM-port arbiter: the host loads RAM while the CPU is halted, then the CPU owns the port.
// Latency: host writes reach RAM one cycle after acceptance; the CPU path to RAM is combinational.
// Backpressure: HOST_READY is high only in LOAD; host words offered in any other state are left pending.
module bat_amateur_boot_arbiter
   import bat_amateur_pkg::*;
#(
   parameter int ADDRESS_WIDTH     = DEFAULT_ADDRESS_WIDTH,
   parameter int DATA_WIDTH        = DEFAULT_DATA_WIDTH,
   parameter int TURNAROUND_CYCLES = 1,
   parameter int STOP_WAIT_CYCLES  = 2
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     HOST_VALID,
   output logic                     HOST_READY,
   input  logic [ADDRESS_WIDTH-1:0] HOST_ADDR,
   input  logic [DATA_WIDTH-1:0]    HOST_DATA,
   input  logic                     HOST_LAST,
   input  logic                     HOST_LOAD_REQ,
   input  logic                     CPU_RAM_EN,
   input  logic                     CPU_RAM_RW,
   input  logic [ADDRESS_WIDTH-1:0] CPU_ADDR,
   input  logic [DATA_WIDTH-1:0]    CPU_WDATA,
   output logic                     RAM_EN,
   output logic                     RAM_RW,
   output logic [ADDRESS_WIDTH-1:0] RAM_ADDR,
   output logic [DATA_WIDTH-1:0]    RAM_WDATA,
   output logic                     HALT,
   output logic                     RUNNING,
   output logic [15:0]              LOAD_COUNT
);

   arb_state_e state, state_nxt;

   logic                     xfer;
   logic                     wait_load;
   logic [WAIT_W-1:0]        wait_val;
   logic                     wait_zero;
   logic                     wr_vld;
   logic [ADDRESS_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0]    wr_dat;
   logic [15:0]              load_count;

   assign xfer = (state == LOAD) && HOST_VALID;

   bat_amateur_wait_counter #(
      .WIDTH (WAIT_W)
   ) u_wait (
      .clk      (CLK),
      .reset    (RESET),
      .load     (wait_load),
      .load_val (wait_val),
      .zero     (wait_zero)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   // RELEASE lasts one write cycle plus the turnaround; STOP lasts exactly the wait window.
   always_comb begin
      state_nxt = state;
      wait_load = 1'b0;
      wait_val  = '0;
      case (state)
         LOAD: begin
            if (xfer && HOST_LAST) begin
               state_nxt = RELEASE;
               wait_load = 1'b1;
               wait_val  = WAIT_W'(TURNAROUND_CYCLES);
            end
         end
         RELEASE: begin
            if (wait_zero) state_nxt = RUN;
         end
         RUN: begin
            if (HOST_LOAD_REQ) begin
               state_nxt = STOP;
               wait_load = 1'b1;
               wait_val  = WAIT_W'(STOP_WAIT_CYCLES - 1);
            end
         end
         STOP: begin
            if (wait_zero) state_nxt = LOAD;
         end
         default: state_nxt = LOAD;
      endcase
   end

   // Host write stage: one registered write per accepted word, dropped on reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_vld     <= 1'b0;
         wr_addr    <= '0;
         wr_dat     <= '0;
         load_count <= '0;
      end else begin
         wr_vld <= xfer;
         if (xfer) begin
            wr_addr <= HOST_ADDR;
            wr_dat  <= HOST_DATA;
            if (load_count != 16'hFFFF) load_count <= load_count + 16'd1;
         end
         if ((state == STOP) && wait_zero) load_count <= '0;
      end
   end

   always_comb begin
      HOST_READY = (state == LOAD);
      HALT       = (state != RUN);
      RUNNING    = (state == RUN);
      LOAD_COUNT = load_count;
      if (state == RUN) begin
         RAM_EN    = CPU_RAM_EN;
         RAM_RW    = CPU_RAM_RW;
         RAM_ADDR  = CPU_ADDR;
         RAM_WDATA = CPU_WDATA;
      end else begin
         RAM_EN    = wr_vld;
         RAM_RW    = wr_vld ? RAM_WRITE : RAM_READ;
         RAM_ADDR  = wr_addr;
         RAM_WDATA = wr_dat;
      end
   end

endmodule

// File: tb/tb_bat_amateur_boot_arbiter.sv
// Directed bench for the boot arbiter: load session, release, CPU run, stop/reload, reset abort, count saturation.
module tb_bat_amateur_boot_arbiter;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        HOST_VALID;
   logic        HOST_READY;
   logic [15:0] HOST_ADDR;
   logic [15:0] HOST_DATA;
   logic        HOST_LAST;
   logic        HOST_LOAD_REQ;
   logic        CPU_RAM_EN;
   logic        CPU_RAM_RW;
   logic [15:0] CPU_ADDR;
   logic [15:0] CPU_WDATA;
   logic        RAM_EN;
   logic        RAM_RW;
   logic [15:0] RAM_ADDR;
   logic [15:0] RAM_WDATA;
   logic        HALT;
   logic        RUNNING;
   logic [15:0] LOAD_COUNT;

   int n_cmp = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   bat_amateur_boot_arbiter #(
      .ADDRESS_WIDTH     (16),
      .DATA_WIDTH        (16),
      .TURNAROUND_CYCLES (1),
      .STOP_WAIT_CYCLES  (2)
   ) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .HOST_VALID    (HOST_VALID),
      .HOST_READY    (HOST_READY),
      .HOST_ADDR     (HOST_ADDR),
      .HOST_DATA     (HOST_DATA),
      .HOST_LAST     (HOST_LAST),
      .HOST_LOAD_REQ (HOST_LOAD_REQ),
      .CPU_RAM_EN    (CPU_RAM_EN),
      .CPU_RAM_RW    (CPU_RAM_RW),
      .CPU_ADDR      (CPU_ADDR),
      .CPU_WDATA     (CPU_WDATA),
      .RAM_EN        (RAM_EN),
      .RAM_RW        (RAM_RW),
      .RAM_ADDR      (RAM_ADDR),
      .RAM_WDATA     (RAM_WDATA),
      .HALT          (HALT),
      .RUNNING       (RUNNING),
      .LOAD_COUNT    (LOAD_COUNT)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic chk_wr(input string tag, input logic [15:0] a, input logic [15:0] d);
      chk({tag, ".en"},   32'(RAM_EN), 1);
      chk({tag, ".rw"},   32'(RAM_RW), 0);
      chk({tag, ".addr"}, 32'(RAM_ADDR), 32'(a));
      chk({tag, ".data"}, 32'(RAM_WDATA), 32'(d));
   endtask

   initial begin
      RESET = 1'b1;
      HOST_VALID = 1'b0; HOST_ADDR = '0; HOST_DATA = '0; HOST_LAST = 1'b0;
      HOST_LOAD_REQ = 1'b0;
      CPU_RAM_EN = 1'b0; CPU_RAM_RW = 1'b1; CPU_ADDR = '0; CPU_WDATA = '0;
      tick(); tick(); tick();

      chk("rst.halt",  32'(HALT), 1);
      chk("rst.run",   32'(RUNNING), 0);
      chk("rst.rdy",   32'(HOST_READY), 1);
      chk("rst.en",    32'(RAM_EN), 0);
      chk("rst.rw",    32'(RAM_RW), 1);
      chk("rst.addr",  32'(RAM_ADDR), 0);
      chk("rst.wdata", 32'(RAM_WDATA), 0);
      chk("rst.cnt",   32'(LOAD_COUNT), 0);

      RESET = 1'b0;
      tick();
      chk("post_rst.halt", 32'(HALT), 1);
      chk("post_rst.en",   32'(RAM_EN), 0);
      chk("post_rst.rdy",  32'(HOST_READY), 1);

      // Three back-to-back words, then the last word.
      HOST_VALID = 1'b1; HOST_ADDR = 16'h0010; HOST_DATA = 16'h0005;
      tick();
      chk_wr("w0", 16'h0010, 16'h0005);
      chk("w0.cnt", 32'(LOAD_COUNT), 1);
      HOST_ADDR = 16'h0011; HOST_DATA = 16'h0000;
      tick();
      chk_wr("w1", 16'h0011, 16'h0000);
      chk("w1.cnt", 32'(LOAD_COUNT), 2);
      HOST_ADDR = 16'h0012; HOST_DATA = 16'h0001;
      tick();
      chk_wr("w2", 16'h0012, 16'h0001);
      chk("w2.cnt",  32'(LOAD_COUNT), 3);
      chk("w2.halt", 32'(HALT), 1);
      HOST_ADDR = 16'h000E; HOST_DATA = 16'h400E; HOST_LAST = 1'b1;
      tick();
      chk_wr("last", 16'h000E, 16'h400E);
      chk("last.rdy",  32'(HOST_READY), 0);
      chk("last.halt", 32'(HALT), 1);
      chk("last.cnt",  32'(LOAD_COUNT), 4);
      HOST_VALID = 1'b0; HOST_LAST = 1'b0;
      tick();
      chk("turn.en",   32'(RAM_EN), 0);
      chk("turn.halt", 32'(HALT), 1);
      chk("turn.run",  32'(RUNNING), 0);
      tick();
      chk("run.halt", 32'(HALT), 0);
      chk("run.run",  32'(RUNNING), 1);

      // CPU owns the port; host words are refused.
      CPU_RAM_EN = 1'b1; CPU_RAM_RW = 1'b1; CPU_ADDR = 16'h0006; CPU_WDATA = 16'h1234;
      HOST_VALID = 1'b1; HOST_ADDR = 16'h0020; HOST_DATA = 16'hDEAD;
      #1;
      chk("cpu_rd.en",   32'(RAM_EN), 1);
      chk("cpu_rd.rw",   32'(RAM_RW), 1);
      chk("cpu_rd.addr", 32'(RAM_ADDR), 16'h0006);
      chk("cpu_rd.rdy",  32'(HOST_READY), 0);
      tick();
      CPU_RAM_RW = 1'b0; CPU_ADDR = 16'h0007; CPU_WDATA = 16'hBEEF;
      #1;
      chk("cpu_wr.rw",    32'(RAM_RW), 0);
      chk("cpu_wr.addr",  32'(RAM_ADDR), 16'h0007);
      chk("cpu_wr.wdata", 32'(RAM_WDATA), 16'hBEEF);
      chk("cpu_wr.cnt",   32'(LOAD_COUNT), 4);
      chk("cpu_wr.run",   32'(RUNNING), 1);

      // Reload request: halt, block the CPU for two cycles, then back to LOAD.
      HOST_LOAD_REQ = 1'b1;
      tick();
      HOST_LOAD_REQ = 1'b0; HOST_VALID = 1'b0;
      chk("stop0.halt", 32'(HALT), 1);
      chk("stop0.en",   32'(RAM_EN), 0);
      chk("stop0.run",  32'(RUNNING), 0);
      chk("stop0.rdy",  32'(HOST_READY), 0);
      tick();
      chk("stop1.halt", 32'(HALT), 1);
      chk("stop1.en",   32'(RAM_EN), 0);
      chk("stop1.rdy",  32'(HOST_READY), 0);
      tick();
      chk("reload.rdy",  32'(HOST_READY), 1);
      chk("reload.cnt",  32'(LOAD_COUNT), 0);
      chk("reload.halt", 32'(HALT), 1);
      chk("reload.en",   32'(RAM_EN), 0);

      // Reset on the same edge as an accepted word aborts the write.
      HOST_VALID = 1'b1; HOST_ADDR = 16'h0030; HOST_DATA = 16'h0077; RESET = 1'b1;
      tick();
      RESET = 1'b0; HOST_VALID = 1'b0;
      chk("rst_abort.en",  32'(RAM_EN), 0);
      chk("rst_abort.cnt", 32'(LOAD_COUNT), 0);
      chk("rst_abort.rdy", 32'(HOST_READY), 1);
      tick();
      chk("rst_abort.en2", 32'(RAM_EN), 0);

      // 0x10000 transfers without LAST: count saturates, writes continue.
      HOST_VALID = 1'b1; HOST_LAST = 1'b0;
      for (int i = 0; i < 65536; i++) begin
         HOST_ADDR = 16'(i);
         HOST_DATA = ~16'(i);
         tick();
         if (i == 65533) chk("sat.cnt_fffe", 32'(LOAD_COUNT), 16'hFFFE);
      end
      chk("sat.cnt_ffff", 32'(LOAD_COUNT), 16'hFFFF);
      chk_wr("sat.lastw", 16'hFFFF, 16'h0000);
      HOST_ADDR = 16'h5A5A; HOST_DATA = 16'h1111;
      tick();
      chk("sat.cnt_hold", 32'(LOAD_COUNT), 16'hFFFF);
      chk_wr("sat.more", 16'h5A5A, 16'h1111);
      HOST_VALID = 1'b0;
      tick();
      chk("sat.idle_en", 32'(RAM_EN), 0);
      chk("sat.idle_rw", 32'(RAM_RW), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
